// File: rtl/tone_decoder_if.sv
// Signal bundle between a buzzer-drive source and the tone decoder.
// The master drives the tone and observes the decoded note; the slave is the decoder.
interface tone_decoder_if;
  logic        tone_in;
  logic [3:0]  note_code;
  logic        note_valid;
  logic        note_start;
  logic        note_end;
  logic [26:0] note_len;

  modport master (
    output tone_in,
    input  note_code,
    input  note_valid,
    input  note_start,
    input  note_end,
    input  note_len
  );

  modport slave (
    input  tone_in,
    output note_code,
    output note_valid,
    output note_start,
    output note_end,
    output note_len
  );
endinterface

// File: rtl/tone_decoder.sv
// Tone decoder: measures half-periods of a buzzer square wave, classifies them against a
// note table and locks onto a note after LOCK_COUNT consecutive matches.
module tone_decoder #(
  parameter int unsigned  LOCK_COUNT = 4,
  parameter int unsigned  TOL        = 1024,
  parameter int unsigned  MIN_HALF   = 1000,
  parameter int unsigned  TIMEOUT    = 200000,
  // Half-period of code n lives in bits [18*n-1 -: 18]; code 1 is the least significant entry.
  parameter logic [179:0] HALF_TABLE = {18'd42554, 18'd47802, 18'd50608, 18'd56819, 18'd63777,
                                        18'd71634, 18'd75874, 18'd85180, 18'd95603, 18'd101217}
) (
  input  logic          clk,
  input  logic          rst_n,
  tone_decoder_if.slave bus
);

  localparam int            CW         = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] LOCK_W     = CW'(LOCK_COUNT);
  localparam logic [18:0]   TOL_W      = 19'(TOL);
  localparam logic [18:0]   MIN_W      = 19'(MIN_HALF);
  localparam logic [17:0]   TIMEOUT_W  = 18'(TIMEOUT);
  localparam logic [17:0]   TIMEOUT_M1 = 18'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t        state_reg;
  logic [2:0]    sync_reg;
  logic [17:0]   cnt_reg;
  logic [3:0]    cand_reg;
  logic [CW-1:0] match_cnt_reg;
  logic [CW-1:0] miss_cnt_reg;
  logic [3:0]    code_reg;
  logic          valid_reg;
  logic          start_reg;
  logic          end_reg;
  logic [26:0]   len_reg;

  logic          tone_edge;
  logic          timeout_hit;
  logic [18:0]   h_val;
  logic [9:0]    match;
  logic [3:0]    cls_next;
  logic [3:0]    cand_next;
  logic [CW-1:0] match_cnt_next;
  logic          lock_now;
  logic          miss_limit;

  // sync_reg[2] is the delayed copy of the synchronized level, used only for edge detection.
  assign tone_edge   = sync_reg[2] ^ sync_reg[1];
  assign timeout_hit = (cnt_reg == TIMEOUT_M1);
  assign h_val       = {1'b0, cnt_reg} + 19'd1;

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_match
      localparam logic [18:0] ENTRY = {1'b0, HALF_TABLE[18*gi +: 18]};
      logic [18:0] diff;
      assign diff      = (h_val >= ENTRY) ? (h_val - ENTRY) : (ENTRY - h_val);
      assign match[gi] = (diff <= TOL_W);
    end
  endgenerate

  // Code 0 stands for both PAUSE and NOMATCH: every state treats them alike.
  always_comb begin
    cls_next = 4'd0;
    if (h_val >= MIN_W) begin
      for (int i = 9; i >= 0; i--) begin
        if (match[i]) begin
          cls_next = 4'(i + 1);
        end
      end
    end
  end

  always_comb begin
    cand_next      = 4'd0;
    match_cnt_next = '0;
    if (cls_next != 4'd0) begin
      if (cls_next == cand_reg) begin
        cand_next      = cand_reg;
        match_cnt_next = match_cnt_reg + CW'(1);
      end else begin
        cand_next      = cls_next;
        match_cnt_next = CW'(1);
      end
    end
  end

  assign lock_now   = (cls_next != 4'd0) && (match_cnt_next == LOCK_W);
  assign miss_limit = ((miss_cnt_reg + CW'(1)) == LOCK_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sync_reg      <= '0;
      cnt_reg       <= '0;
      cand_reg      <= '0;
      match_cnt_reg <= '0;
      miss_cnt_reg  <= '0;
      code_reg      <= '0;
      valid_reg     <= 1'b0;
      start_reg     <= 1'b0;
      end_reg       <= 1'b0;
      len_reg       <= '0;
    end else begin
      sync_reg  <= {sync_reg[1:0], bus.tone_in};
      start_reg <= 1'b0;
      end_reg   <= 1'b0;

      if (tone_edge) begin
        cnt_reg <= '0;
      end else if (cnt_reg < TIMEOUT_W) begin
        cnt_reg <= cnt_reg + 18'd1;
      end

      case (state_reg)
        IDLE: begin
          // The first edge only starts the measurement; its half-period is partial.
          if (tone_edge) begin
            state_reg     <= ACQUIRE;
            cand_reg      <= '0;
            match_cnt_reg <= '0;
          end
        end

        ACQUIRE: begin
          if (tone_edge) begin
            if (lock_now) begin
              state_reg     <= LOCKED;
              code_reg      <= cand_next;
              valid_reg     <= 1'b1;
              start_reg     <= 1'b1;
              len_reg       <= '0;
              miss_cnt_reg  <= '0;
              cand_reg      <= '0;
              match_cnt_reg <= '0;
            end else begin
              cand_reg      <= cand_next;
              match_cnt_reg <= match_cnt_next;
            end
          end else if (timeout_hit) begin
            state_reg     <= IDLE;
            code_reg      <= '0;
            cand_reg      <= '0;
            match_cnt_reg <= '0;
            miss_cnt_reg  <= '0;
          end
        end

        LOCKED: begin
          if (len_reg != '1) begin
            len_reg <= len_reg + 27'd1;
          end
          if (tone_edge) begin
            if (cls_next == code_reg) begin
              miss_cnt_reg <= '0;
            end else if (miss_limit) begin
              // Lock lost: restart acquisition from scratch, keep the measured length.
              state_reg     <= ACQUIRE;
              code_reg      <= '0;
              valid_reg     <= 1'b0;
              end_reg       <= 1'b1;
              len_reg       <= len_reg;
              miss_cnt_reg  <= '0;
              cand_reg      <= '0;
              match_cnt_reg <= '0;
            end else begin
              miss_cnt_reg <= miss_cnt_reg + CW'(1);
            end
          end else if (timeout_hit) begin
            state_reg     <= IDLE;
            code_reg      <= '0;
            valid_reg     <= 1'b0;
            end_reg       <= 1'b1;
            len_reg       <= len_reg;
            miss_cnt_reg  <= '0;
            cand_reg      <= '0;
            match_cnt_reg <= '0;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.note_code  = code_reg;
  assign bus.note_valid = valid_reg;
  assign bus.note_start = start_reg;
  assign bus.note_end   = end_reg;
  assign bus.note_len   = len_reg;

endmodule

// File: doc/tone_decoder.md
TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 Parameter LOCK_COUNT, default 4: consecutive matching half-periods needed to lock or unlock.
REQ-002 Parameter TOL, default 1024: match tolerance in clk cycles, applied +/- to each table entry.
REQ-003 Parameter MIN_HALF, default 1000: half-periods below this classify as PAUSE tone.
REQ-004 Parameter TIMEOUT, default 200000: clk cycles without an edge that mean silence.
REQ-005 clk  input  1  system clock (100 MHz); the block uses one clock; reset is asynchronous and active-low.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 tone_in  input  1  asynchronous square-wave tone (buzzer drive signal).
REQ-008 note_code  output  4  locked note: 0 none, 1 L_7, 2 M_1, 3 M_2, 4 M_3, 5 M_4, 6 M_5, 7 M_6, 8 M_7, 9 H_1, 10 H_2.
REQ-009 note_valid  output  1  high while in LOCKED.
REQ-010 note_start  output  1  one-cycle pulse on entry to LOCKED.
REQ-011 note_end  output  1  one-cycle pulse on exit from LOCKED.
REQ-012 note_len  output  27  clk cycles elapsed in the current or last lock, saturating at all-ones.

Function
REQ-013 tone_in SHALL pass through a 2-flop synchronizer; an edge is any level change of the synchronized signal, detected one cycle later.
REQ-014 An 18-bit half-period counter SHALL increment each cycle, saturate at TIMEOUT, and on an edge capture its value plus 1 as H, then restart at 0.
REQ-015 Table half-periods (cycles) SHALL be: 101217, 95603, 85180, 75874, 71634, 63777, 56819, 50608, 47802, 42554 for codes 1-10.
REQ-016 Classification of H SHALL be: H < MIN_HALF gives PAUSE; |H - entry| <= TOL gives that code; otherwise NOMATCH.
REQ-017 The first edge after IDLE SHALL only restart the counter; its H is discarded as a partial period.
REQ-018 States SHALL be IDLE, ACQUIRE and LOCKED, with IDLE as the reset state.
REQ-019 IDLE -> ACQUIRE SHALL occur on the first edge.
REQ-020 In ACQUIRE, a code 1-10 equal to the previous candidate SHALL increment the match count.
REQ-021 In ACQUIRE, a different code 1-10 SHALL become the new candidate with match count 1.
REQ-022 In ACQUIRE, PAUSE or NOMATCH SHALL clear the candidate and the match count.
REQ-023 ACQUIRE -> LOCKED SHALL occur when the match count reaches LOCK_COUNT.
REQ-024 On entering LOCKED: note_code <= candidate, note_start pulses, note_len <= 0.
REQ-025 In LOCKED, note_len SHALL increment every cycle (saturating).
REQ-026 In LOCKED, a classification equal to note_code SHALL clear the miss count; any other classification SHALL increment it.
REQ-027 LOCKED -> ACQUIRE SHALL occur at LOCK_COUNT consecutive misses; note_end pulses, note_code <= 0, note_len holds.
REQ-028 A new note after a lock loss SHALL relock only through the full ACQUIRE sequence.
REQ-029 From ACQUIRE or LOCKED, the counter reaching TIMEOUT SHALL go to IDLE, pulse note_end if leaving LOCKED, set note_code <= 0, and clear the match and miss counts.
REQ-030 If an edge and TIMEOUT occur in the same cycle, the edge SHALL take priority.
REQ-031 note_start and note_end SHALL never be asserted in the same cycle.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 While rst_n = 0, the block SHALL hold state IDLE and clear all counters, candidate, note_code, note_valid, note_start, note_end and note_len to 0; the synchronizer flops SHALL clear to 0.
REQ-034 Reset asserted mid-lock SHALL clear the outputs immediately with no note_end pulse.

Verification
REQ-035 tone_in square wave with half-period 75874 -> note_start after the 5th edge (the 1st edge is discarded, then 4 matches), note_code = 4, note_valid = 1.
REQ-036 Locked on code 4, then tone switches to half-period 63777 -> note_end after 4 misses, then note_start with note_code = 6 after 4 further matches.
REQ-037 Half-period 100 (PAUSE) for 20 edges -> note_valid stays 0 and note_code stays 0.
REQ-038 Locked tone, then tone_in held constant -> note_end exactly TIMEOUT cycles after the last edge, state IDLE, note_len frozen.
REQ-039 Half-period 49200 (between M_7 and H_1 windows) -> NOMATCH, never locks.
REQ-040 rst_n pulsed low while locked -> all outputs 0 asynchronously, no note_end pulse; after release, relock requires 5 edges.
